// File: rtl/am2901_useq_if.sv
// am2901_useq_if: bus joining the sequencer to its control-store ROM and one Am2901 slice
//   uaddr/uinstr : control-store address out, microword back (asynchronous ROM)
//   i/a/b/d/cin/oe : registered slice fields, oe active-low
//   z/ovr/f3/cout  : live slice status
interface am2901_useq_if #(parameter int AW = 6);
  logic [AW-1:0] uaddr;
  logic [27+AW:0] uinstr;
  logic z, ovr, f3, cout;
  logic [8:0] i;
  logic [3:0] a, b, d;
  logic cin, oe;
  modport master (output uaddr, i, a, b, d, cin, oe, input uinstr, z, ovr, f3, cout);
  modport slave (input uaddr, i, a, b, d, cin, oe, output uinstr, z, ovr, f3, cout);
endinterface

// File: rtl/am2901_useq.sv
// am2901_useq: microprogram sequencer driving one Am2901 slice from an asynchronous control store
//   cp, rst_lo     : clock, synchronous active-low reset
//   start/start_addr : run request and entry address, honoured in IDLE and HALT
//   busy, halted   : RUN / HALT indicators; stk_err : sticky stack over/underflow
//   bus            : master side of am2901_useq_if (ROM address/data, slice fields, status)
module am2901_useq #(
  parameter int AW = 6,
  parameter int SD = 4
) (
  input  logic          cp,
  input  logic          rst_lo,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          halted,
  output logic          stk_err,
  am2901_useq_if.master bus
);
  localparam int SPW = $clog2(SD + 1);
  localparam int IW = SD > 1 ? $clog2(SD) : 1;
  localparam logic [21:0] NOP = 22'h67;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q;
  logic [AW-1:0] pc_q, pc_d, ctr_q, ctr_d, pc_inc, tgt;
  logic [AW-1:0] stk_q [SD];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0] top;
  logic [21:0] pipe_q;
  logic [7:0] cond;
  logic [2:0] op;
  logic oe_q, busy_q, halted_q, err_q, err_d, push, cc_ok, full, empty;
  assign op = bus.uinstr[24:22];
  assign tgt = bus.uinstr[27+AW:28];
  // condition is evaluated on live status, i.e. the result of the word already in the pipeline
  assign cond = {1'b0, ~bus.cout, bus.cout, bus.f3, bus.ovr, ~bus.z, bus.z, 1'b1};
  assign cc_ok = cond[bus.uinstr[27:25]];
  assign pc_inc = pc_q + 1'b1;
  assign full = sp_q == SPW'(SD);
  assign empty = sp_q == '0;
  assign top = IW'(sp_q - 1'b1);
  always_comb begin
    pc_d = pc_inc;
    ctr_d = ctr_q;
    sp_d = sp_q;
    push = 1'b0;
    err_d = err_q;
    case (op)
      3'd1: pc_d = cc_ok ? tgt : pc_inc;
      3'd2: if (cc_ok) begin
        err_d = err_q | full;
        push = !full;
        sp_d = full ? sp_q : sp_q + 1'b1;
        pc_d = full ? pc_inc : tgt;
      end
      3'd3: if (cc_ok) begin
        err_d = err_q | empty;
        sp_d = empty ? sp_q : sp_q - 1'b1;
        pc_d = empty ? pc_inc : stk_q[top];
      end
      3'd4: ctr_d = tgt;
      3'd5: if (ctr_q != '0) begin
        ctr_d = ctr_q - 1'b1;
        pc_d = tgt;
      end
      3'd6: pc_d = pc_q;
      default: ;
    endcase
  end
  always_ff @(posedge cp) begin
    if (!rst_lo) begin
      state_q <= IDLE;
      pc_q <= '0;
      ctr_q <= '0;
      sp_q <= '0;
      pipe_q <= NOP;
      oe_q <= 1'b1;
      busy_q <= 1'b0;
      halted_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q == RUN) begin
      pipe_q <= bus.uinstr[21:0];
      oe_q <= 1'b0;
      pc_q <= pc_d;
      ctr_q <= ctr_d;
      sp_q <= sp_d;
      err_q <= err_d;
      if (push) stk_q[IW'(sp_q)] <= pc_inc;
      if (op == 3'd6) begin
        state_q <= HALT;
        busy_q <= 1'b0;
        halted_q <= 1'b1;
      end
    end else begin
      pipe_q <= NOP;
      oe_q <= state_q == IDLE;
      if (start) begin
        pc_q <= start_addr;
        state_q <= RUN;
        busy_q <= 1'b1;
        halted_q <= 1'b0;
      end
    end
  end
  assign bus.uaddr = pc_q;
  assign {bus.cin, bus.d, bus.b, bus.a, bus.i} = pipe_q;
  assign bus.oe = oe_q;
  assign busy = busy_q;
  assign halted = halted_q;
  assign stk_err = err_q;
endmodule
